// File: rtl/sfft_pkg.sv
// Shared defaults and FSM encoding for the SFFT post-processing blocks.
package sfft_pkg;

  localparam int NFFT_LOG2_DEFAULT  = 9;
  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int N_BANDS_DEFAULT    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // Band-select width; a single band still needs a 1-bit select port.
  function automatic int band_width(input int n_bands);
    return (n_bands > 1) ? $clog2(n_bands) : 1;
  endfunction

endpackage

// File: rtl/peak_compare.sv
// Magnitude of one SFFT bin checked against one band's running maximum.
module peak_compare #(
  parameter int NFFT_LOG2  = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic [NFFT_LOG2-1:0]  bin_idx,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [NFFT_LOG2-1:0]  max_bin,
  input  logic [DATA_WIDTH-1:0] max_mag,
  output logic [NFFT_LOG2-1:0]  upd_bin,
  output logic [DATA_WIDTH-1:0] upd_mag
);

  localparam logic [DATA_WIDTH-1:0] MAG_SAT  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] mag;

  always_comb begin
    mag = '0;
    // DC carries no spectral peak information, so it never competes.
    if (bin_idx == '0) begin
      mag = '0;
    end else if (data == MOST_NEG) begin
      mag = MAG_SAT;
    end else if (data[DATA_WIDTH-1]) begin
      mag = -data;
    end else begin
      mag = data;
    end
  end

  // Strictly greater only: earlier (lower) bins keep the peak on ties.
  always_comb begin
    upd_bin = max_bin;
    upd_mag = max_mag;
    if (mag > max_mag) begin
      upd_bin = bin_idx;
      upd_mag = mag;
    end
  end

endmodule

// File: rtl/spectral_peak_finder.sv
// Scans each completed SFFT frame and commits the largest-magnitude bin of
// every equal-width band to host-readable result registers.
module spectral_peak_finder
  import sfft_pkg::*;
#(
  parameter int NFFT_LOG2  = NFFT_LOG2_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int N_BANDS    = N_BANDS_DEFAULT,
  localparam int BAND_W    = band_width(N_BANDS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_valid,
  output logic [NFFT_LOG2-1:0]         bin_addr,
  input  logic signed [DATA_WIDTH-1:0] bin_data,
  input  logic                         output_being_read,
  input  logic [BAND_W-1:0]            rd_band,
  output logic [NFFT_LOG2-1:0]         rd_bin,
  output logic [DATA_WIDTH-1:0]        rd_mag,
  output logic                         peaks_valid,
  output logic                         busy,
  output logic [31:0]                  frame_count,
  output logic                         overrun
);

  localparam int BAND_SHIFT = NFFT_LOG2 - $clog2(N_BANDS);
  localparam logic [NFFT_LOG2-1:0] LAST_BIN = '1;

  state_t state_reg, state_next;
  logic   commit;

  logic                  fv_reg, fv_prev_reg;
  logic                  frame_event;
  logic [NFFT_LOG2-1:0]  addr_reg;
  logic                  rd_valid_reg;
  logic [NFFT_LOG2-1:0]  rd_bin_reg;
  logic                  peaks_valid_reg;
  logic [31:0]           frame_count_reg;
  logic                  overrun_reg;

  logic [BAND_W-1:0]                    cur_band;
  logic [NFFT_LOG2-1:0]                 upd_bin;
  logic [DATA_WIDTH-1:0]                upd_mag;
  logic [N_BANDS-1:0][NFFT_LOG2-1:0]    work_bin_vec, res_bin_vec;
  logic [N_BANDS-1:0][DATA_WIDTH-1:0]   work_mag_vec, res_mag_vec;

  // Edge detector powers up "already high" so a level held through reset
  // must drop before it can start a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      fv_reg      <= 1'b1;
      fv_prev_reg <= 1'b1;
    end else begin
      fv_reg      <= frame_valid;
      fv_prev_reg <= fv_reg;
    end
  end

  assign frame_event = fv_reg & ~fv_prev_reg;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    commit     = 1'b0;
    case (state_reg)
      IDLE:   if (frame_event) state_next = SCAN;
      SCAN:   if (addr_reg == LAST_BIN) state_next = DRAIN;
      DRAIN:  state_next = COMMIT;
      COMMIT: begin
        if (!output_being_read) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // rd_bin_reg tracks which bin the current bin_data word belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg        <= '0;
      rd_valid_reg    <= 1'b0;
      rd_bin_reg      <= '0;
      peaks_valid_reg <= 1'b0;
      frame_count_reg <= '0;
      overrun_reg     <= 1'b0;
    end else begin
      rd_valid_reg    <= (state_reg == SCAN);
      rd_bin_reg      <= addr_reg;
      peaks_valid_reg <= commit;
      if (state_reg == SCAN) addr_reg <= addr_reg + 1'b1;
      else                   addr_reg <= '0;
      if (commit) frame_count_reg <= frame_count_reg + 32'd1;
      if (frame_event && (state_reg != IDLE)) overrun_reg <= 1'b1;
    end
  end

  assign cur_band = BAND_W'(rd_bin_reg >> BAND_SHIFT);

  peak_compare #(
    .NFFT_LOG2  (NFFT_LOG2),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_peak_compare (
    .bin_idx (rd_bin_reg),
    .data    (bin_data),
    .max_bin (work_bin_vec[cur_band]),
    .max_mag (work_mag_vec[cur_band]),
    .upd_bin (upd_bin),
    .upd_mag (upd_mag)
  );

  for (genvar gi = 0; gi < N_BANDS; gi++) begin : g_band
    logic [NFFT_LOG2-1:0]  work_bin_reg, res_bin_reg;
    logic [DATA_WIDTH-1:0] work_mag_reg, res_mag_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        work_bin_reg <= '0;
        work_mag_reg <= '0;
        res_bin_reg  <= '0;
        res_mag_reg  <= '0;
      end else begin
        if ((state_reg == IDLE) && frame_event) begin
          work_bin_reg <= '0;
          work_mag_reg <= '0;
        end else if (rd_valid_reg && (cur_band == BAND_W'(gi))) begin
          work_bin_reg <= upd_bin;
          work_mag_reg <= upd_mag;
        end
        if (commit) begin
          res_bin_reg <= work_bin_reg;
          res_mag_reg <= work_mag_reg;
        end
      end
    end

    assign work_bin_vec[gi] = work_bin_reg;
    assign work_mag_vec[gi] = work_mag_reg;
    assign res_bin_vec[gi]  = res_bin_reg;
    assign res_mag_vec[gi]  = res_mag_reg;
  end

  assign bin_addr    = addr_reg;
  assign rd_bin      = res_bin_vec[rd_band];
  assign rd_mag      = res_mag_vec[rd_band];
  assign peaks_valid = peaks_valid_reg;
  assign busy        = (state_reg != IDLE);
  assign frame_count = frame_count_reg;
  assign overrun     = overrun_reg;

endmodule
